// File: rtl/fifo_rd_pkg.sv
// Shared types and default widths for the FIFO pair reader.
package fifo_rd_pkg;

    typedef enum logic {S_A, S_B} rd_state_t;

    localparam int BW_DEF = 16;
    localparam int CW_DEF = 16;

endpackage

// File: rtl/fifo_pair_reader.sv
// Pop-side consumer for a show-ahead FIFO. Each two consecutive words form an
// operand pair (A, B) that is presented through a registered valid/ready port.
module fifo_pair_reader
    import fifo_rd_pkg::*;
#(
    parameter int bW = BW_DEF,
    parameter int cW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [bW-1:0] popData,
    input  logic          empty,
    output logic          pop,
    input  logic          flush,
    output logic [bW-1:0] outA,
    output logic [bW-1:0] outB,
    output logic          outValid,
    input  logic          outReady,
    output logic [cW-1:0] pairCnt
);

    rd_state_t     state, state_nxt;
    logic [bW-1:0] a_reg;
    logic          xfer;

    assign xfer = outValid && outReady;

    // Pop decision and next state. In S_B a pop would overwrite the output
    // register, so it is only allowed when that register is free or draining.
    always_comb begin
        pop       = 1'b0;
        state_nxt = state;
        if (!rst && !flush && !empty) begin
            case (state)
                S_A:     pop = 1'b1;
                S_B:     pop = !outValid || outReady;
                default: pop = 1'b0;
            endcase
        end
        if (pop) begin
            state_nxt = (state == S_A) ? S_B : S_A;
        end
        if (flush) begin
            state_nxt = S_A;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand A holding register, output pair register and valid flag.
    // A reload in the same cycle as a transfer keeps outValid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            outA     <= '0;
            outB     <= '0;
            outValid <= 1'b0;
        end else begin
            if (pop && state == S_A) begin
                a_reg <= popData;
            end
            if (pop && state == S_B) begin
                outA     <= a_reg;
                outB     <= popData;
                outValid <= 1'b1;
            end else if (xfer) begin
                outValid <= 1'b0;
            end
        end
    end

    // Count of pairs accepted downstream; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            pairCnt <= '0;
        end else if (xfer) begin
            pairCnt <= pairCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_pair_reader.sv
// Bench for fifo_pair_reader: behavioural show-ahead FIFO in front of the DUT,
// gold model is a queue of pairs built from the words pushed into the FIFO.
module tb_fifo_pair_reader;

    localparam int BW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] popData = '0;
    logic          empty = 1'b1;
    logic          pop;
    logic          flush = 1'b0;
    logic [BW-1:0] outA;
    logic [BW-1:0] outB;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [CW-1:0] pairCnt;

    logic          push = 1'b0;
    logic [BW-1:0] push_data = '0;

    logic [BW-1:0]   fq[$];
    logic [2*BW-1:0] gold_q[$];
    logic [BW-1:0]   gold_half;
    bit              has_half = 0;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int npops = 0;
    int delivered = 0;
    int hs_cyc[$];
    logic [2*BW-1:0] last_pair = '0;

    fifo_pair_reader #(.bW(BW), .cW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .popData  (popData),
        .empty    (empty),
        .pop      (pop),
        .flush    (flush),
        .outA     (outA),
        .outB     (outB),
        .outValid (outValid),
        .outReady (outReady),
        .pairCnt  (pairCnt)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: head and empty flag registered off the queue.
    always @(posedge clk) begin
        if (pop && fq.size() > 0) void'(fq.pop_front());
        if (push) fq.push_back(push_data);
        empty   <= (fq.size() == 0);
        popData <= (fq.size() > 0) ? fq[0] : '0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample at negedge, drive inputs, then check the pop and
    // handshake that the coming posedge will act on.
    task automatic cyc(input bit pe, input logic [BW-1:0] d, input bit rdy,
                       input bit fl, input bit rs);
        @(negedge clk);
        cyc_n++;
        push = pe; push_data = d; outReady = rdy; flush = fl; rst = rs;
        if (pe) begin
            if (has_half) begin
                gold_q.push_back({gold_half, d});
                has_half = 0;
            end else begin
                gold_half = d;
                has_half = 1;
            end
        end
        #1;
        chk("pop_while_empty", {63'd0, pop && empty}, 64'd0);
        if (pop) npops++;
        if (outValid && outReady && !rst) begin
            if (gold_q.size() == 0) begin
                chk("unexpected_pair", {32'd0, outA, outB}, 64'd0);
            end else begin
                chk("pair", {32'd0, outA, outB}, {32'd0, gold_q.pop_front()});
            end
            delivered++;
            hs_cyc.push_back(cyc_n);
            last_pair = {outA, outB};
        end
    endtask

    initial begin
        int d0;
        logic [BW-1:0] w [4];
        w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444;

        // Reset with four words queued: nothing may be popped.
        for (int i = 0; i < 4; i++) begin
            cyc(1, w[i], 0, 0, 1);
            chk("rst_pop", {63'd0, pop}, 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("rst_pop", {63'd0, pop}, 64'd0);
        end
        @(negedge clk);
        chk("rst_valid", {63'd0, outValid}, 64'd0);
        chk("rst_outA", {48'd0, outA}, 64'd0);
        chk("rst_outB", {48'd0, outB}, 64'd0);
        chk("rst_cnt", {60'd0, pairCnt}, 64'd0);

        // Streaming the four queued words with outReady high.
        hs_cyc.delete();
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0);
        chk("stream_pairs", 64'(hs_cyc.size()), 64'd2);
        if (hs_cyc.size() == 2) chk("stream_spacing", 64'(hs_cyc[1] - hs_cyc[0]), 64'd2);
        chk("stream_cnt", {60'd0, pairCnt}, 64'd2);
        chk("stream_empty", {63'd0, empty}, 64'd1);

        // Backpressure: downstream stalls while four more words arrive.
        npops = 0;
        for (int i = 0; i < 4; i++) cyc(1, w[i], 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk("bp_valid", {63'd0, outValid}, 64'd1);
            chk("bp_hold", {32'd0, outA, outB}, 64'h11112222);
            chk("bp_pop", {63'd0, pop}, 64'd0);
        end
        chk("bp_npops", 64'(npops), 64'd3);
        chk("bp_fifo_left", 64'(fq.size()), 64'd1);
        cyc(0, 0, 1, 0, 0);
        chk("bp_reload_pop", {63'd0, pop}, 64'd1);
        cyc(0, 0, 1, 0, 0);
        chk("bp_next_valid", {63'd0, outValid}, 64'd1);
        chk("bp_next_pair", {32'd0, outA, outB}, 64'h33334444);
        cyc(0, 0, 1, 0, 0);
        chk("bp_cnt", {60'd0, pairCnt}, 64'd4);

        // Flush with A held: AAAA must be discarded.
        cyc(1, 16'hAAAA, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk("flush_pop", {63'd0, pop}, 64'd0);
        has_half = 0;
        d0 = delivered;
        cyc(1, 16'hBBBB, 1, 0, 0);
        cyc(1, 16'hCCCC, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
        chk("flush_npairs", 64'(delivered - d0), 64'd1);
        chk("flush_pair", {32'd0, last_pair}, 64'hBBBBCCCC);
        chk("flush_cnt", {60'd0, pairCnt}, 64'd5);

        // Odd word: reader parks holding A until the partner arrives.
        cyc(1, 16'h0001, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        chk("odd_pop", {63'd0, pop}, 64'd0);
        chk("odd_valid", {63'd0, outValid}, 64'd0);
        chk("odd_fifo", 64'(fq.size()), 64'd0);
        cyc(1, 16'h0002, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        chk("odd_pair", {32'd0, last_pair}, 64'h00010002);
        chk("odd_cnt", {60'd0, pairCnt}, 64'd6);

        // Random push / outReady traffic; counter wraps at 16.
        for (int i = 0; i < 20000; i++)
            cyc(bit'($urandom_range(0, 1)), BW'($urandom), bit'($urandom_range(0, 1)), 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0);
        chk("rand_cnt", {60'd0, pairCnt}, 64'(delivered % 16));
        chk("rand_drain", 64'(gold_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
